// File: rtl/ysyx_23060072_if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_23060072_if_fetch_ctrl
//  Purpose  : IF-stage fetch controller. Owns the fetch PC and keeps at most
//             one memory request outstanding. Each returned word is shown to
//             the external combinational BPU, whose decision selects the next
//             PC (predicted target or PC+4). EX redirects override the PC and
//             squash any word already in flight. The fetched word is handed
//             to ID as {pc, instr, predict_taken} with a valid/ready handshake.
//  Ports    :
//    clk, rst                  clock, synchronous active-high reset
//    ifu_req_*                 fetch request channel (valid/ready, address)
//    ifu_rsp_*                 fetch response channel (valid/ready, data)
//    bpu_instr_rdata/addr_o    word and its address presented to the BPU
//    bpu_predict_flag/pc_i     BPU decision for the presented word
//    redirect_valid/pc_i       EX redirect (pc bits [1:0] ignored)
//    if_valid_o / if_ready_i   IF/ID handshake
//    if_pc/instr/predict_o     IF/ID payload (zero unless if_valid_o)
//  Revision : 1.0  initial release
// ============================================================================
module ysyx_23060072_if_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   // fetch request channel
   output logic        ifu_req_valid_o,
   input  logic        ifu_req_ready_i,
   output logic [31:0] ifu_req_addr_o,
   // fetch response channel
   input  logic        ifu_rsp_valid_i,
   output logic        ifu_rsp_ready_o,
   input  logic [31:0] ifu_rsp_data_i,
   // branch predictor interface
   output logic [31:0] bpu_instr_rdata_o,
   output logic [31:0] bpu_instr_addr_o,
   input  logic        bpu_predict_flag_i,
   input  logic [31:0] bpu_predict_pc_i,
   // redirect from EX
   input  logic        redirect_valid_i,
   input  logic [31:0] redirect_pc_i,
   // IF/ID handshake
   output logic        if_valid_o,
   input  logic        if_ready_i,
   output logic [31:0] if_pc_o,
   output logic [31:0] if_instr_o,
   output logic        if_predict_taken_o
);

   // ------------------------------------------------------------------------
   // State encoding
   // ------------------------------------------------------------------------
   localparam logic [1:0] S_IDLE = 2'd0;   // load request address from PC
   localparam logic [1:0] S_REQ  = 2'd1;   // request presented to memory
   localparam logic [1:0] S_WAIT = 2'd2;   // waiting for the response word
   localparam logic [1:0] S_HOLD = 2'd3;   // payload offered to ID

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   logic [1:0]  r_state;
   logic [31:0] r_pc;          // PC of the next fetch
   logic [31:0] r_req_addr;    // address of the current/outstanding request
   logic [31:0] r_instr;       // held instruction word
   logic [31:0] r_ipc;         // PC of the held instruction
   logic        r_ptaken;      // BPU decision for the held instruction
   logic        r_drop;        // the in-flight word belongs to a squashed path

   // ------------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------------
   logic [1:0]  w_state_nxt;
   logic        w_redirect;    // redirect that actually takes effect
   logic [31:0] w_redirect_pc;
   logic [31:0] w_seq_pc;
   logic [31:0] w_next_pc;
   logic        w_req_fire;
   logic        w_rsp_fire;
   logic        w_id_fire;
   logic        w_is_hold;

   // Masking keeps every redirect target word aligned.
   assign w_redirect_pc = redirect_pc_i & 32'hFFFF_FFFC;
   // Wraps naturally modulo 2^32.
   assign w_seq_pc      = r_req_addr + 32'd4;
   assign w_next_pc     = bpu_predict_flag_i ? bpu_predict_pc_i : w_seq_pc;

   // Redirects are not accepted in IDLE; IDLE only lasts one cycle.
   assign w_redirect = redirect_valid_i && (r_state != S_IDLE);

   assign w_req_fire = ifu_req_valid_o && ifu_req_ready_i;
   assign w_rsp_fire = ifu_rsp_valid_i && ifu_rsp_ready_o;
   assign w_id_fire  = if_valid_o && if_ready_i;
   assign w_is_hold  = (r_state == S_HOLD);

   // The BPU looks at the word as it arrives, paired with its request address.
   assign bpu_instr_rdata_o = ifu_rsp_data_i;
   assign bpu_instr_addr_o  = r_req_addr;
   assign ifu_req_addr_o    = r_req_addr;

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            w_state_nxt = S_REQ;
         end
         S_REQ: begin
            // A redirect here does not cancel the request; the word is
            // dropped on return instead, so the address stays stable.
            if (w_req_fire) begin
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (w_rsp_fire) begin
               if (w_redirect || r_drop) begin
                  w_state_nxt = S_REQ;
               end else begin
                  w_state_nxt = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (w_redirect) begin
               w_state_nxt = S_IDLE;
            end else if (w_id_fire) begin
               w_state_nxt = S_REQ;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------------
   always_comb begin
      ifu_req_valid_o    = 1'b0;
      ifu_rsp_ready_o    = 1'b0;
      if_valid_o         = 1'b0;
      if_pc_o            = 32'd0;
      if_instr_o         = 32'd0;
      if_predict_taken_o = 1'b0;
      case (r_state)
         S_REQ:  ifu_req_valid_o = 1'b1;
         S_WAIT: ifu_rsp_ready_o = 1'b1;
         S_HOLD: begin
            if_valid_o         = 1'b1;
            if_pc_o            = r_ipc;
            if_instr_o         = r_instr;
            if_predict_taken_o = r_ptaken;
         end
         default: begin
            ifu_req_valid_o = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc       <= RESET_PC;
         r_req_addr <= 32'd0;
         r_instr    <= 32'd0;
         r_ipc      <= 32'd0;
         r_ptaken   <= 1'b0;
         r_drop     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_req_addr <= r_pc;
            end
            S_REQ: begin
               if (w_redirect) begin
                  r_pc   <= w_redirect_pc;
                  r_drop <= 1'b1;
               end
            end
            S_WAIT: begin
               if (w_rsp_fire) begin
                  if (w_redirect) begin
                     // The arriving word is the one being squashed, so no
                     // further drop is owed: go straight to the new target.
                     r_pc       <= w_redirect_pc;
                     r_req_addr <= w_redirect_pc;
                     r_drop     <= 1'b0;
                  end else if (r_drop) begin
                     r_drop     <= 1'b0;
                     r_req_addr <= r_pc;
                  end else begin
                     r_instr  <= ifu_rsp_data_i;
                     r_ipc    <= r_req_addr;
                     r_ptaken <= bpu_predict_flag_i;
                     r_pc     <= w_next_pc;
                  end
               end else if (w_redirect) begin
                  r_pc   <= w_redirect_pc;
                  r_drop <= 1'b1;
               end
            end
            S_HOLD: begin
               if (w_redirect) begin
                  r_pc <= w_redirect_pc;
               end else if (w_id_fire) begin
                  r_req_addr <= r_pc;
               end
            end
            default: begin
               r_drop <= 1'b0;
            end
         endcase
      end
   end

   // Keeps the hold decode visible as a single named term for debug probes.
   logic w_hold_unused;
   assign w_hold_unused = w_is_hold & 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060072_if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_23060072_if_fetch_ctrl
//  Purpose  : Bench for the IF fetch controller. Provides a static BPU, a
//             one-outstanding memory with configurable latency, directed
//             scenarios, and a randomized run checked against an
//             instruction-stream reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ysyx_23060072_if_fetch_ctrl;

   localparam logic [31:0] C_RESET_PC = 32'h8000_0000;
   localparam logic [31:0] C_NOP      = 32'h0000_0013;
   localparam logic [31:0] C_JAL_P8   = 32'h0080_006F;
   localparam logic [31:0] C_JAL_M8   = 32'hFF9F_F06F;
   localparam logic [31:0] C_BEQ_M4   = 32'hFE00_0EE3;
   localparam logic [31:0] C_BEQ_P8   = 32'h0000_0463;
   localparam logic [31:0] C_ADDI     = 32'h0010_0093;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ifu_req_valid_o;
   logic        ifu_req_ready_i = 1'b0;
   logic [31:0] ifu_req_addr_o;
   logic        ifu_rsp_valid_i;
   logic        ifu_rsp_ready_o;
   logic [31:0] ifu_rsp_data_i;
   logic [31:0] bpu_instr_rdata_o;
   logic [31:0] bpu_instr_addr_o;
   logic        bpu_predict_flag_i;
   logic [31:0] bpu_predict_pc_i;
   logic        redirect_valid_i = 1'b0;
   logic [31:0] redirect_pc_i = 32'd0;
   logic        if_valid_o;
   logic        if_ready_i = 1'b0;
   logic [31:0] if_pc_o;
   logic [31:0] if_instr_o;
   logic        if_predict_taken_o;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   ysyx_23060072_if_fetch_ctrl #(.RESET_PC(C_RESET_PC)) dut (
      .clk                (clk),
      .rst                (rst),
      .ifu_req_valid_o    (ifu_req_valid_o),
      .ifu_req_ready_i    (ifu_req_ready_i),
      .ifu_req_addr_o     (ifu_req_addr_o),
      .ifu_rsp_valid_i    (ifu_rsp_valid_i),
      .ifu_rsp_ready_o    (ifu_rsp_ready_o),
      .ifu_rsp_data_i     (ifu_rsp_data_i),
      .bpu_instr_rdata_o  (bpu_instr_rdata_o),
      .bpu_instr_addr_o   (bpu_instr_addr_o),
      .bpu_predict_flag_i (bpu_predict_flag_i),
      .bpu_predict_pc_i   (bpu_predict_pc_i),
      .redirect_valid_i   (redirect_valid_i),
      .redirect_pc_i      (redirect_pc_i),
      .if_valid_o         (if_valid_o),
      .if_ready_i         (if_ready_i),
      .if_pc_o            (if_pc_o),
      .if_instr_o         (if_instr_o),
      .if_predict_taken_o (if_predict_taken_o)
   );

   // ------------------------------------------------------------------------
   // Instruction memory contents: fixed words for directed scenarios, hashed
   // mix of sequential / jump / branch words elsewhere.
   // ------------------------------------------------------------------------
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] h;
      case (a)
         32'h8000_0000: return C_NOP;
         32'h8000_0004: return C_JAL_P8;
         32'h8000_0008: return C_NOP;
         32'h8000_000C: return C_BEQ_M4;
         32'h8000_0100: return C_NOP;
         32'h8000_0200: return C_NOP;
         32'h8000_0300: return C_NOP;
         32'hFFFF_FFFC: return C_NOP;
         default: begin
            h = a * 32'h9E37_79B1;
            case (h[31:29])
               3'd0, 3'd1: return C_NOP;
               3'd2, 3'd3: return C_ADDI;
               3'd4:       return C_JAL_P8;
               3'd5:       return C_BEQ_M4;
               3'd6:       return C_BEQ_P8;
               default:    return C_JAL_M8;
            endcase
         end
      endcase
   endfunction

   // Static predictor: JAL always taken, conditional branches taken when
   // backward. Returns {taken, next pc}.
   function automatic logic [32:0] bpu_model(input logic [31:0] w, input logic [31:0] pc);
      logic [31:0] imm;
      if (w[6:0] == 7'b1101111) begin
         imm = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
         return {1'b1, pc + imm};
      end else if (w[6:0] == 7'b1100011 && w[31]) begin
         imm = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
         return {1'b1, pc + imm};
      end
      return {1'b0, pc + 32'd4};
   endfunction

   assign {bpu_predict_flag_i, bpu_predict_pc_i} = bpu_model(bpu_instr_rdata_o, bpu_instr_addr_o);

   // ------------------------------------------------------------------------
   // Memory: accepts one request, answers mem_delay cycles after the
   // 1-cycle minimum. Runs on the falling edge so its drives are settled
   // before the DUT samples them.
   // ------------------------------------------------------------------------
   int          mem_delay  = 0;
   bit          rand_ready = 1'b0;
   bit          mem_busy   = 1'b0;
   bit          acc_next   = 1'b0;
   bit          cons_next  = 1'b0;
   int          mem_cnt    = 0;
   int          mon_viol   = 0;
   logic [31:0] acc_addr   = 32'd0;
   logic [31:0] mem_addr   = 32'd0;
   logic        mem_rsp_valid = 1'b0;
   logic [31:0] mem_rsp_data  = 32'd0;
   logic        spur_valid = 1'b0;
   logic [31:0] spur_data  = 32'd0;

   assign ifu_rsp_valid_i = mem_rsp_valid | spur_valid;
   assign ifu_rsp_data_i  = spur_valid ? spur_data : mem_rsp_data;

   always @(negedge clk) begin
      if (rst) begin
         mem_busy      = 1'b0;
         acc_next      = 1'b0;
         cons_next     = 1'b0;
         mem_cnt       = 0;
         mem_rsp_valid = 1'b0;
         mem_rsp_data  = 32'd0;
         ifu_req_ready_i = 1'b1;
      end else begin
         if (cons_next) begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = 32'd0;
            mem_busy      = 1'b0;
         end
         if (acc_next) begin
            mem_busy = 1'b1;
            mem_addr = acc_addr;
            mem_cnt  = mem_delay;
         end
         if (mem_busy && !mem_rsp_valid) begin
            if (mem_cnt == 0) begin
               mem_rsp_valid = 1'b1;
               mem_rsp_data  = mem_word(mem_addr);
            end else begin
               mem_cnt = mem_cnt - 1;
            end
         end
         ifu_req_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (ifu_req_valid_o && mem_busy) mon_viol = mon_viol + 1;
         acc_next  = ifu_req_valid_o && ifu_req_ready_i && !mem_busy;
         acc_addr  = ifu_req_addr_o;
         cons_next = mem_rsp_valid && ifu_rsp_ready_o;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_if_valid(output int n);
      n = 0;
      while (!if_valid_o && n < 30) begin
         tick();
         n++;
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_checks++;
      if ({ifu_req_valid_o, ifu_rsp_ready_o, if_valid_o, if_predict_taken_o} !== 4'b0 ||
          if_pc_o !== 32'd0 || if_instr_o !== 32'd0 || ifu_req_addr_o !== 32'd0) begin
         n_errors++;
         $display("FAIL reset_outputs: got req_v=%b rsp_r=%b if_v=%b pt=%b pc=%h instr=%h addr=%h, expected all zero",
                  ifu_req_valid_o, ifu_rsp_ready_o, if_valid_o, if_predict_taken_o, if_pc_o, if_instr_o, ifu_req_addr_o);
      end
      rst = 1'b0;
      tick();
      n_checks++;
      if (ifu_req_valid_o !== 1'b1 || ifu_req_addr_o !== C_RESET_PC || ifu_rsp_ready_o !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_first_req: got req_v=%b addr=%h rsp_r=%b, expected 1 %h 0",
                  ifu_req_valid_o, ifu_req_addr_o, ifu_rsp_ready_o, C_RESET_PC);
      end
   endtask

   task automatic test_sequential();
      tick();
      n_checks++;
      if (ifu_rsp_ready_o !== 1'b1 || ifu_req_valid_o !== 1'b0) begin
         n_errors++;
         $display("FAIL seq_wait: got rsp_r=%b req_v=%b, expected 1 0", ifu_rsp_ready_o, ifu_req_valid_o);
      end
      tick();
      n_checks++;
      if (if_valid_o !== 1'b1 || if_pc_o !== 32'h8000_0000 || if_instr_o !== C_NOP || if_predict_taken_o !== 1'b0) begin
         n_errors++;
         $display("FAIL seq_payload: got v=%b pc=%h instr=%h pt=%b, expected 1 80000000 %h 0",
                  if_valid_o, if_pc_o, if_instr_o, if_predict_taken_o, C_NOP);
      end
      if_ready_i = 1'b1;
      tick();
      if_ready_i = 1'b0;
      n_checks++;
      if (ifu_req_valid_o !== 1'b1 || ifu_req_addr_o !== 32'h8000_0004 || if_valid_o !== 1'b0) begin
         n_errors++;
         $display("FAIL seq_next_req: got req_v=%b addr=%h if_v=%b, expected 1 80000004 0",
                  ifu_req_valid_o, ifu_req_addr_o, if_valid_o);
      end
   endtask

   task automatic test_predict();
      logic [31:0] pcs   [2];
      logic [31:0] words [2];
      logic [31:0] nxt   [2];
      int n;
      pcs[0] = 32'h8000_0004; words[0] = C_JAL_P8; nxt[0] = 32'h8000_000C;
      pcs[1] = 32'h8000_000C; words[1] = C_BEQ_M4; nxt[1] = 32'h8000_0008;
      for (int i = 0; i < 2; i++) begin
         wait_if_valid(n);
         n_checks++;
         if (if_valid_o !== 1'b1 || n !== 2 || if_pc_o !== pcs[i] || if_instr_o !== words[i] || if_predict_taken_o !== 1'b1) begin
            n_errors++;
            $display("FAIL predict_payload_%0d: got v=%b lat=%0d pc=%h instr=%h pt=%b, expected 1 2 %h %h 1",
                     i, if_valid_o, n, if_pc_o, if_instr_o, if_predict_taken_o, pcs[i], words[i]);
         end
         if_ready_i = 1'b1;
         tick();
         if_ready_i = 1'b0;
         n_checks++;
         if (ifu_req_valid_o !== 1'b1 || ifu_req_addr_o !== nxt[i]) begin
            n_errors++;
            $display("FAIL predict_next_%0d: got req_v=%b addr=%h, expected 1 %h", i, ifu_req_valid_o, ifu_req_addr_o, nxt[i]);
         end
      end
   endtask

   task automatic test_redirect_wait();
      int n;
      bit saw;
      mem_delay = 2;
      tick();
      n_checks++;
      if (ifu_rsp_ready_o !== 1'b1) begin
         n_errors++;
         $display("FAIL rdw_in_wait: got rsp_r=%b, expected 1", ifu_rsp_ready_o);
      end
      redirect_valid_i = 1'b1;
      redirect_pc_i    = 32'h8000_0100;
      tick();
      redirect_valid_i = 1'b0;
      n = 0;
      saw = 1'b0;
      while (!ifu_req_valid_o && n < 20) begin
         if (if_valid_o) saw = 1'b1;
         tick();
         n++;
      end
      mem_delay = 0;
      n_checks++;
      if (saw || if_valid_o !== 1'b0 || ifu_req_valid_o !== 1'b1 || ifu_req_addr_o !== 32'h8000_0100) begin
         n_errors++;
         $display("FAIL rdw_drop: got saw_valid=%b req_v=%b addr=%h, expected 0 1 80000100",
                  saw, ifu_req_valid_o, ifu_req_addr_o);
      end
      wait_if_valid(n);
      n_checks++;
      if (if_valid_o !== 1'b1 || if_pc_o !== 32'h8000_0100 || if_instr_o !== C_NOP) begin
         n_errors++;
         $display("FAIL rdw_target: got v=%b pc=%h instr=%h, expected 1 80000100 %h", if_valid_o, if_pc_o, if_instr_o, C_NOP);
      end
      if_ready_i = 1'b1;
      tick();
      if_ready_i = 1'b0;
   endtask

   task automatic test_same_cycle_redirect();
      int n;
      tick();
      redirect_valid_i = 1'b1;
      redirect_pc_i    = 32'h8000_0200;
      tick();
      redirect_valid_i = 1'b0;
      n_checks++;
      if (ifu_req_valid_o !== 1'b1 || ifu_req_addr_o !== 32'h8000_0200 || if_valid_o !== 1'b0) begin
         n_errors++;
         $display("FAIL same_cycle_req: got req_v=%b addr=%h if_v=%b, expected 1 80000200 0",
                  ifu_req_valid_o, ifu_req_addr_o, if_valid_o);
      end
      wait_if_valid(n);
      n_checks++;
      if (if_valid_o !== 1'b1 || n !== 2 || if_pc_o !== 32'h8000_0200) begin
         n_errors++;
         $display("FAIL same_cycle_nodrop: got v=%b lat=%0d pc=%h, expected 1 2 80000200", if_valid_o, n, if_pc_o);
      end
   endtask

   task automatic test_hold_redirect();
      int n;
      redirect_valid_i = 1'b1;
      redirect_pc_i    = 32'h8000_0300;
      tick();
      redirect_valid_i = 1'b0;
      n_checks++;
      if (if_valid_o !== 1'b0 || ifu_req_valid_o !== 1'b0 || ifu_rsp_ready_o !== 1'b0) begin
         n_errors++;
         $display("FAIL hold_redirect_idle: got if_v=%b req_v=%b rsp_r=%b, expected 0 0 0",
                  if_valid_o, ifu_req_valid_o, ifu_rsp_ready_o);
      end
      tick();
      n_checks++;
      if (ifu_req_valid_o !== 1'b1 || ifu_req_addr_o !== 32'h8000_0300) begin
         n_errors++;
         $display("FAIL hold_redirect_req: got req_v=%b addr=%h, expected 1 80000300", ifu_req_valid_o, ifu_req_addr_o);
      end
      wait_if_valid(n);
      n_checks++;
      if (if_valid_o !== 1'b1 || if_pc_o !== 32'h8000_0300) begin
         n_errors++;
         $display("FAIL hold_redirect_target: got v=%b pc=%h, expected 1 80000300", if_valid_o, if_pc_o);
      end
      if_ready_i = 1'b1;
      tick();
      if_ready_i = 1'b0;
   endtask

   task automatic test_backpressure();
      int n;
      logic [32:0] pred;
      logic [31:0] w;
      w    = mem_word(32'h8000_0304);
      pred = bpu_model(w, 32'h8000_0304);
      wait_if_valid(n);
      n_checks++;
      if (if_valid_o !== 1'b1 || if_pc_o !== 32'h8000_0304 || if_instr_o !== w || if_predict_taken_o !== pred[32]) begin
         n_errors++;
         $display("FAIL bp_payload: got v=%b pc=%h instr=%h pt=%b, expected 1 80000304 %h %b",
                  if_valid_o, if_pc_o, if_instr_o, if_predict_taken_o, w, pred[32]);
      end
      // A stray response outside WAIT must not disturb the held payload.
      spur_valid = 1'b1;
      spur_data  = 32'hDEAD_BEEF;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++;
         if (if_valid_o !== 1'b1 || ifu_req_valid_o !== 1'b0 || if_pc_o !== 32'h8000_0304 ||
             if_instr_o !== w || if_predict_taken_o !== pred[32]) begin
            n_errors++;
            $display("FAIL bp_stall_%0d: got v=%b req_v=%b pc=%h instr=%h pt=%b, expected 1 0 80000304 %h %b",
                     i, if_valid_o, ifu_req_valid_o, if_pc_o, if_instr_o, if_predict_taken_o, w, pred[32]);
         end
      end
      spur_valid = 1'b0;
      if_ready_i = 1'b1;
      tick();
      if_ready_i = 1'b0;
      n_checks++;
      if (ifu_req_valid_o !== 1'b1 || ifu_req_addr_o !== pred[31:0]) begin
         n_errors++;
         $display("FAIL bp_release: got req_v=%b addr=%h, expected 1 %h", ifu_req_valid_o, ifu_req_addr_o, pred[31:0]);
      end
   endtask

   task automatic test_wrap();
      int n;
      // Redirect while the request is presented; low bits must be ignored.
      redirect_valid_i = 1'b1;
      redirect_pc_i    = 32'hFFFF_FFFE;
      tick();
      redirect_valid_i = 1'b0;
      wait_if_valid(n);
      n_checks++;
      if (if_valid_o !== 1'b1 || if_pc_o !== 32'hFFFF_FFFC || if_instr_o !== C_NOP || if_predict_taken_o !== 1'b0) begin
         n_errors++;
         $display("FAIL wrap_target: got v=%b pc=%h instr=%h pt=%b, expected 1 fffffffc %h 0",
                  if_valid_o, if_pc_o, if_instr_o, if_predict_taken_o, C_NOP);
      end
      if_ready_i = 1'b1;
      tick();
      if_ready_i = 1'b0;
      n_checks++;
      if (ifu_req_valid_o !== 1'b1 || ifu_req_addr_o !== 32'h0000_0000) begin
         n_errors++;
         $display("FAIL wrap_next: got req_v=%b addr=%h, expected 1 00000000", ifu_req_valid_o, ifu_req_addr_o);
      end
   endtask

   task automatic test_reset_abort();
      int n;
      mem_delay = 2;
      tick();
      tick();
      rst = 1'b1;
      tick();
      n_checks++;
      if ({ifu_req_valid_o, ifu_rsp_ready_o, if_valid_o} !== 3'b0 || ifu_req_addr_o !== 32'd0) begin
         n_errors++;
         $display("FAIL abort_idle: got req_v=%b rsp_r=%b if_v=%b addr=%h, expected 0 0 0 0",
                  ifu_req_valid_o, ifu_rsp_ready_o, if_valid_o, ifu_req_addr_o);
      end
      rst = 1'b0;
      mem_delay = 0;
      tick();
      n_checks++;
      if (ifu_req_valid_o !== 1'b1 || ifu_req_addr_o !== C_RESET_PC) begin
         n_errors++;
         $display("FAIL abort_req: got req_v=%b addr=%h, expected 1 %h", ifu_req_valid_o, ifu_req_addr_o, C_RESET_PC);
      end
      wait_if_valid(n);
      n_checks++;
      if (if_valid_o !== 1'b1 || if_pc_o !== C_RESET_PC || if_instr_o !== C_NOP) begin
         n_errors++;
         $display("FAIL abort_refetch: got v=%b pc=%h instr=%h, expected 1 %h %h", if_valid_o, if_pc_o, if_instr_o, C_RESET_PC, C_NOP);
      end
   endtask

   // ------------------------------------------------------------------------
   // Randomized run. The reference model tracks only the architectural
   // instruction stream: the PC the next delivered instruction must carry,
   // advanced by the predictor rule and overridden by accepted redirects.
   // ------------------------------------------------------------------------
   task automatic test_random();
      logic [31:0] exp_pc, w, rnd, p_pc, p_instr;
      logic [32:0] pred;
      logic        p_pt, idle, hold_prev;
      int          ndel, since, viol0;
      bit          stuck;
      rst = 1'b1;
      if_ready_i = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      exp_pc = C_RESET_PC;
      rand_ready = 1'b1;
      hold_prev = 1'b0;
      p_pc = 32'd0; p_instr = 32'd0; p_pt = 1'b0;
      ndel = 0; since = 0; stuck = 1'b0;
      viol0 = mon_viol;
      for (int c = 0; c < 4000 && !stuck; c++) begin
         if (hold_prev) begin
            n_checks++;
            if (if_valid_o !== 1'b1 || if_pc_o !== p_pc || if_instr_o !== p_instr || if_predict_taken_o !== p_pt) begin
               n_errors++;
               $display("FAIL rand_stable cyc %0d: got v=%b pc=%h instr=%h pt=%b, expected 1 %h %h %b",
                        c, if_valid_o, if_pc_o, if_instr_o, if_predict_taken_o, p_pc, p_instr, p_pt);
            end
         end
         idle = !(ifu_req_valid_o || ifu_rsp_ready_o || if_valid_o);
         if_ready_i       = ($urandom_range(0, 3) != 0);
         redirect_valid_i = ($urandom_range(0, 19) == 0);
         rnd              = $urandom;
         redirect_pc_i    = {20'h80000, rnd[11:0]};
         mem_delay        = $urandom_range(0, 2);
         if (if_valid_o && if_ready_i) begin
            w    = mem_word(exp_pc);
            pred = bpu_model(w, exp_pc);
            n_checks++;
            if (if_pc_o !== exp_pc || if_instr_o !== w || if_predict_taken_o !== pred[32]) begin
               n_errors++;
               $display("FAIL rand_payload #%0d: got pc=%h instr=%h pt=%b, expected %h %h %b",
                        ndel, if_pc_o, if_instr_o, if_predict_taken_o, exp_pc, w, pred[32]);
            end
            exp_pc = pred[31:0];
            ndel++;
            since = 0;
         end
         if (redirect_valid_i && !idle) exp_pc = redirect_pc_i & 32'hFFFF_FFFC;
         hold_prev = if_valid_o && !if_ready_i && !(redirect_valid_i && !idle);
         p_pc = if_pc_o; p_instr = if_instr_o; p_pt = if_predict_taken_o;
         since++;
         if (since > 200) stuck = 1'b1;
         tick();
      end
      redirect_valid_i = 1'b0;
      if_ready_i = 1'b0;
      rand_ready = 1'b0;
      n_checks++;
      if (stuck || ndel < 100) begin
         n_errors++;
         $display("FAIL rand_progress: got delivered=%0d stalled=%b, expected >=100 and 0", ndel, stuck);
      end
      n_checks++;
      if (mon_viol !== viol0) begin
         n_errors++;
         $display("FAIL one_outstanding: got %0d overlapping requests, expected 0", mon_viol - viol0);
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_predict();
      test_redirect_wait();
      test_same_cycle_redirect();
      test_hold_redirect();
      test_backpressure();
      test_wrap();
      test_reset_abort();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire
